// File: rtl/rv32i_types.sv
// rtl/rv32i_types.sv - shared front-end types for the fetch path
//
// Purpose: types and constants shared by the instruction-fetch front end.
//   fetch_state_t : request tracking state of the fetch buffer.
//   fetch_entry_t : one queued {pc, inst} pair at the default 32-bit XLEN.
//   IMEM_RMASK_WORD : byte mask presented while a word fetch is outstanding.
package rv32i_types;

    typedef enum logic [1:0] {
        IDLE = 2'd0,    // no request outstanding
        WAIT = 2'd1,    // request outstanding, response will be kept
        DROP = 2'd2     // stale request outstanding, response will be discarded
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    localparam logic [3:0] IMEM_RMASK_WORD = 4'hF;

endpackage

// File: rtl/circ_queue.sv
// rtl/circ_queue.sv - circular queue with flush, parametrised on depth and entry type
//
// Purpose: DEPTH-entry FIFO built on a storage array with wrapping head/tail
// pointers. Flush empties the queue and takes priority over enqueue/dequeue.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   flush_i         drop all entries, pointers back to 0
//   enq_i           write enq_data_i at the tail (caller guarantees space or a same-cycle dequeue)
//   enq_data_i      entry to write
//   deq_i           pop the head entry (caller guarantees the queue is not empty)
//   head_data_o     head entry, all zeros while the queue is empty
//   count_o         number of occupied entries, 0..DEPTH
module circ_queue #(
    parameter int  DEPTH   = 8,
    parameter type entry_t = logic [63:0]
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     enq_i,
    input  entry_t                   enq_data_i,
    input  logic                     deq_i,
    output entry_t                   head_data_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);

    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   head_q;
    logic [PTR_W-1:0]   tail_q;
    logic [PTR_W:0]     count_q;

    // Pointers are exactly log2(DEPTH) bits, so +1 wraps modulo DEPTH for free.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (enq_i) begin
                tail_q <= tail_q + 1'b1;
            end
            if (deq_i) begin
                head_q <= head_q + 1'b1;
            end
            case ({enq_i, deq_i})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: nothing is read out unless count_q says it was written.
    // When full with a same-cycle dequeue, tail == head; the head is read from the
    // old contents this cycle and overwritten at the edge, which is the intended order.
    always_ff @(posedge clk_i) begin
        if (enq_i && !flush_i) begin
            mem[tail_q] <= enq_data_i;
        end
    end

    assign head_data_o = (count_q != '0) ? mem[head_q] : '0;
    assign count_o     = count_q;

endmodule

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - instruction-fetch front end with one-outstanding imem request and decode queue
//
// Purpose: owns the PC, issues word reads on imem one at a time and queues the
// returned {pc, inst} pairs for decode. A redirect flushes the queue and turns
// any in-flight fetch into a stale one whose response is discarded.
// Ports:
//   clk_i, rst_ni         clock, asynchronous active-low reset
//   imem_addr_o           fetch address, held from issue through the response cycle
//   imem_rmask_o          4'hF while a request is outstanding, else 4'h0
//   imem_rdata_i          instruction word, qualified by imem_resp_i
//   imem_resp_i           single-cycle response strobe
//   redirect_i            flush request, single cycle
//   redirect_pc_i         new PC, low two bits ignored
//   deq_valid_o           head entry valid (masked during a redirect)
//   deq_ready_i           decode accepts the head entry
//   deq_pc_o, deq_inst_o  head entry
//   count_o               occupied queue entries
module fetch_buffer
    import rv32i_types::*;
#(
    parameter int               DEPTH    = 8,
    parameter int               XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = 32'h1ECE_B000
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    output logic [XLEN-1:0]            imem_addr_o,
    output logic [3:0]                 imem_rmask_o,
    input  logic [XLEN-1:0]            imem_rdata_i,
    input  logic                       imem_resp_i,
    input  logic                       redirect_i,
    input  logic [XLEN-1:0]            redirect_pc_i,
    output logic                       deq_valid_o,
    input  logic                       deq_ready_i,
    output logic [XLEN-1:0]            deq_pc_o,
    output logic [XLEN-1:0]            deq_inst_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } entry_t;

    fetch_state_t       state_q;
    logic [XLEN-1:0]    pc_q;
    logic [XLEN-1:0]    addr_q;
    logic [3:0]         rmask_q;

    logic [CNT_W-1:0]   count_q;
    logic [XLEN-1:0]    redirect_pc_aligned;
    logic               has_space;
    logic               enq;
    logic               deq_fire;
    entry_t             enq_data;
    entry_t             head_data;

    assign redirect_pc_aligned = redirect_pc_i & ~XLEN'(3);

    // Issue only while a slot is free; with a single outstanding request this
    // reserves room for the response, so a kept response can never overflow.
    assign has_space = (count_q < CNT_W'(DEPTH));

    // A same-cycle redirect wins over the response: it is dropped, not queued.
    assign enq      = (state_q == WAIT) && imem_resp_i && !redirect_i;
    assign enq_data = '{pc: addr_q, inst: imem_rdata_i};

    assign deq_valid_o = (count_q != '0) && !redirect_i;
    assign deq_fire    = deq_valid_o && deq_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            rmask_q <= 4'h0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (redirect_i) begin
                        pc_q <= redirect_pc_aligned;
                    end else if (has_space) begin
                        addr_q  <= pc_q;
                        rmask_q <= IMEM_RMASK_WORD;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (redirect_i) begin
                        pc_q <= redirect_pc_aligned;
                        if (imem_resp_i) begin
                            rmask_q <= 4'h0;
                            state_q <= IDLE;
                        end else begin
                            // addr/rmask stay up until the stale response returns
                            state_q <= DROP;
                        end
                    end else if (imem_resp_i) begin
                        pc_q    <= pc_q + XLEN'(4);
                        rmask_q <= 4'h0;
                        state_q <= IDLE;
                    end
                end
                DROP: begin
                    if (redirect_i) begin
                        pc_q <= redirect_pc_aligned;
                    end
                    if (imem_resp_i) begin
                        rmask_q <= 4'h0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    rmask_q <= 4'h0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    circ_queue #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_queue (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .flush_i     (redirect_i),
        .enq_i       (enq),
        .enq_data_i  (enq_data),
        .deq_i       (deq_fire),
        .head_data_o (head_data),
        .count_o     (count_q)
    );

    assign imem_addr_o  = addr_q;
    assign imem_rmask_o = rmask_q;
    assign deq_pc_o     = head_data.pc;
    assign deq_inst_o   = head_data.inst;
    assign count_o      = count_q;

endmodule

// File: tb/tb_fetch_buffer.sv
// tb/tb_fetch_buffer.sv - self-checking bench for fetch_buffer
module tb_fetch_buffer;

    localparam int          DEPTH    = 4;
    localparam int          XLEN     = 32;
    localparam logic [31:0] RESET_PC = 32'h1ECE_B000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [3:0]  imem_rmask;
    logic [31:0] imem_rdata;
    logic        imem_resp;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        deq_valid;
    logic        deq_ready;
    logic [31:0] deq_pc;
    logic [31:0] deq_inst;
    logic [2:0]  count;

    always #5 clk = ~clk;

    fetch_buffer #(.DEPTH(DEPTH), .XLEN(XLEN), .RESET_PC(RESET_PC)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .imem_addr_o   (imem_addr),
        .imem_rmask_o  (imem_rmask),
        .imem_rdata_i  (imem_rdata),
        .imem_resp_i   (imem_resp),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .deq_valid_o   (deq_valid),
        .deq_ready_i   (deq_ready),
        .deq_pc_o      (deq_pc),
        .deq_inst_o    (deq_inst),
        .count_o       (count)
    );

    int checks = 0;
    int passes = 0;

    // Reference model: queue of {pc, inst}, the next PC, and whether a fetch is
    // in flight (and whether its data is still wanted).
    logic [63:0] mq[$];
    logic [31:0] m_pc;
    logic [31:0] m_addr;
    bit          m_out;
    bit          m_stale;

    function automatic void model_reset();
        mq.delete();
        m_pc    = RESET_PC;
        m_addr  = RESET_PC;
        m_out   = 1'b0;
        m_stale = 1'b0;
    endfunction

    function automatic void model_step();
        int sz;
        bit fire;
        sz   = mq.size();
        fire = (sz != 0) && !redirect && deq_ready;
        if (redirect) begin
            mq.delete();
            m_pc = {redirect_pc[31:2], 2'b00};
            if (m_out && imem_resp) begin
                m_out   = 1'b0;
                m_stale = 1'b0;
            end else if (m_out) begin
                m_stale = 1'b1;
            end
        end else begin
            if (fire) void'(mq.pop_front());
            if (m_out) begin
                if (imem_resp) begin
                    if (!m_stale) begin
                        mq.push_back({m_addr, imem_rdata});
                        m_pc = m_pc + 32'd4;
                    end
                    m_out   = 1'b0;
                    m_stale = 1'b0;
                end
            end else if (sz < DEPTH) begin
                m_out  = 1'b1;
                m_addr = m_pc;
            end
        end
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; imem_resp = 1'b0; imem_rdata = '0; redirect = 1'b0;
        redirect_pc = '0; deq_ready = 1'b0;
        model_reset();
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++; if (imem_rmask !== 4'h0) $display("FAIL reset_rmask got %h want 0", imem_rmask); else passes++;
        checks++; if (imem_addr !== RESET_PC) $display("FAIL reset_addr got %h want %h", imem_addr, RESET_PC); else passes++;
        checks++; if (deq_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", deq_valid); else passes++;
        checks++; if (count !== 3'd0) $display("FAIL reset_count got %0d want 0", count); else passes++;
        checks++; if (deq_pc !== 32'h0 || deq_inst !== 32'h0) $display("FAIL reset_head got %h/%h want 0/0", deq_pc, deq_inst); else passes++;
    endtask

    task automatic test_first_fetch();
        rst_n = 1'b1;
        #1;
        checks++; if (imem_rmask !== 4'h0) $display("FAIL first_pre_rmask got %h want 0", imem_rmask); else passes++;
        tick();
        checks++; if (imem_rmask !== 4'hF) $display("FAIL first_rmask got %h want f", imem_rmask); else passes++;
        checks++; if (imem_addr !== 32'h1ECE_B000) $display("FAIL first_addr got %h want 1eceb000", imem_addr); else passes++;
        imem_resp = 1'b1; imem_rdata = 32'h0000_0013;
        #1;
        checks++; if (deq_valid !== 1'b0) $display("FAIL first_no_bypass got %b want 0", deq_valid); else passes++;
        tick();
        imem_resp = 1'b0;
        #1;
        checks++; if (deq_valid !== 1'b1) $display("FAIL first_valid got %b want 1", deq_valid); else passes++;
        checks++; if (deq_pc !== 32'h1ECE_B000) $display("FAIL first_pc got %h want 1eceb000", deq_pc); else passes++;
        checks++; if (deq_inst !== 32'h0000_0013) $display("FAIL first_inst got %h want 00000013", deq_inst); else passes++;
    endtask

    task automatic test_fill();
        deq_ready = 1'b0;
        for (int i = 0; i < 40; i++) begin
            imem_resp = m_out; imem_rdata = $urandom;
            #1;
            tick();
        end
        imem_resp = 1'b0;
        #1;
        checks++; if (count !== 3'd4) $display("FAIL fill_count got %0d want 4", count); else passes++;
        checks++; if (imem_rmask !== 4'h0) $display("FAIL fill_no_fifth got %h want 0", imem_rmask); else passes++;
        deq_ready = 1'b1;
        #1;
        checks++; if (deq_pc !== 32'h1ECE_B000) $display("FAIL fill_head got %h want 1eceb000", deq_pc); else passes++;
        tick();
        deq_ready = 1'b0;
        #1;
        checks++; if (count !== 3'd3) $display("FAIL fill_after_deq got %0d want 3", count); else passes++;
        tick();
        checks++; if (imem_rmask !== 4'hF) $display("FAIL fill_fifth_rmask got %h want f", imem_rmask); else passes++;
        checks++; if (imem_addr !== 32'h1ECE_B010) $display("FAIL fill_fifth_addr got %h want 1eceb010", imem_addr); else passes++;
    endtask

    task automatic test_stream_order();
        logic [31:0] exp_pc;
        exp_pc = 32'h1ECE_B004;
        deq_ready = 1'b1;
        for (int i = 0; i < 60; i++) begin
            imem_resp = m_out; imem_rdata = $urandom;
            #1;
            if (mq.size() != 0) begin
                checks++; if (deq_valid !== 1'b1 || deq_pc !== exp_pc) $display("FAIL stream_pc cycle %0d got %b/%h want 1/%h", i, deq_valid, deq_pc, exp_pc); else passes++;
                exp_pc = exp_pc + 32'd4;
            end
            tick();
        end
        imem_resp = 1'b0; deq_ready = 1'b0;
    endtask

    task automatic test_redirect_wait();
        for (int i = 0; i < 20 && !m_out; i++) tick();
        checks++; if (!m_out) $display("FAIL redir_wait_timeout got idle want outstanding"); else passes++;
        redirect = 1'b1; redirect_pc = 32'h0000_1002;
        #1;
        checks++; if (deq_valid !== 1'b0) $display("FAIL redir_valid_mask got %b want 0", deq_valid); else passes++;
        tick();
        redirect = 1'b0;
        #1;
        checks++; if (imem_rmask !== 4'hF) $display("FAIL redir_drop_rmask got %h want f", imem_rmask); else passes++;
        tick();
        imem_resp = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        #1;
        tick();
        imem_resp = 1'b0;
        #1;
        checks++; if (count !== 3'd0) $display("FAIL redir_stale_dropped got %0d want 0", count); else passes++;
        tick();
        checks++; if (imem_rmask !== 4'hF || imem_addr !== 32'h0000_1000) $display("FAIL redir_new_req got %h/%h want f/00001000", imem_rmask, imem_addr); else passes++;
        imem_resp = 1'b1; imem_rdata = 32'h0000_0093;
        #1;
        tick();
        imem_resp = 1'b0;
        #1;
        checks++; if (deq_valid !== 1'b1 || deq_pc !== 32'h0000_1000) $display("FAIL redir_first_pc got %b/%h want 1/00001000", deq_valid, deq_pc); else passes++;
    endtask

    task automatic test_redirect_resp_deq();
        bit ready_state;
        ready_state = 1'b0;
        deq_ready = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (mq.size() == 3 && m_out) begin
                ready_state = 1'b1;
                break;
            end
            imem_resp = m_out && (mq.size() < 3); imem_rdata = $urandom;
            #1;
            tick();
        end
        checks++; if (!ready_state) $display("FAIL rdd_setup_timeout got %0d entries want 3 plus outstanding", mq.size()); else passes++;
        checks++; if (count !== 3'd3) $display("FAIL rdd_count3 got %0d want 3", count); else passes++;
        redirect = 1'b1; redirect_pc = 32'h0000_2000; imem_resp = 1'b1; imem_rdata = 32'h1111_1111; deq_ready = 1'b1;
        #1;
        checks++; if (deq_valid !== 1'b0) $display("FAIL rdd_valid_mask got %b want 0", deq_valid); else passes++;
        tick();
        redirect = 1'b0; imem_resp = 1'b0; deq_ready = 1'b0;
        #1;
        checks++; if (count !== 3'd0 || deq_valid !== 1'b0) $display("FAIL rdd_flush got %0d/%b want 0/0", count, deq_valid); else passes++;
        checks++; if (imem_rmask !== 4'h0) $display("FAIL rdd_resp_dropped got %h want 0", imem_rmask); else passes++;
        tick();
        checks++; if (imem_rmask !== 4'hF || imem_addr !== 32'h0000_2000) $display("FAIL rdd_new_req got %h/%h want f/00002000", imem_rmask, imem_addr); else passes++;
    endtask

    task automatic test_pc_wrap();
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE;
        #1;
        tick();
        redirect = 1'b0;
        for (int i = 0; i < 20 && mq.size() == 0; i++) begin
            imem_resp = m_out; imem_rdata = $urandom;
            #1;
            tick();
        end
        imem_resp = 1'b0;
        #1;
        checks++; if (deq_pc !== 32'hFFFF_FFFC) $display("FAIL wrap_head_pc got %h want fffffffc", deq_pc); else passes++;
        tick();
        checks++; if (imem_rmask !== 4'hF || imem_addr !== 32'h0) $display("FAIL wrap_next_addr got %h/%h want f/00000000", imem_rmask, imem_addr); else passes++;
    endtask

    task automatic test_random();
        logic [31:0] e_pc, e_inst;
        int          errs;
        errs = 0;
        for (int i = 0; i < 1500; i++) begin
            redirect    = ($urandom_range(0, 19) == 0);
            redirect_pc = $urandom;
            deq_ready   = $urandom_range(0, 1);
            imem_resp   = m_out && ($urandom_range(0, 2) != 0);
            imem_rdata  = $urandom;
            #1;
            e_pc   = (mq.size() != 0) ? mq[0][63:32] : 32'h0;
            e_inst = (mq.size() != 0) ? mq[0][31:0]  : 32'h0;
            checks++;
            if (count !== 3'(mq.size()) || deq_valid !== ((mq.size() != 0) && !redirect) ||
                imem_rmask !== (m_out ? 4'hF : 4'h0) || imem_addr !== m_addr ||
                deq_pc !== e_pc || deq_inst !== e_inst) begin
                if (errs < 10)
                    $display("FAIL random cycle %0d got cnt=%0d v=%b rm=%h a=%h pc=%h in=%h want cnt=%0d v=%b rm=%h a=%h pc=%h in=%h",
                             i, count, deq_valid, imem_rmask, imem_addr, deq_pc, deq_inst,
                             mq.size(), (mq.size() != 0) && !redirect, m_out ? 4'hF : 4'h0, m_addr, e_pc, e_inst);
                errs++;
            end else begin
                passes++;
            end
            tick();
        end
        redirect = 1'b0; imem_resp = 1'b0; deq_ready = 1'b0;
    endtask

    task automatic test_reset_mid_wait();
        for (int i = 0; i < 20 && !(m_out && !m_stale); i++) begin
            imem_resp = 1'b0;
            #1;
            tick();
        end
        checks++; if (!m_out) $display("FAIL rst_mid_setup got idle want outstanding"); else passes++;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++; if (imem_rmask !== 4'h0 || imem_addr !== RESET_PC) $display("FAIL rst_mid_imem got %h/%h want 0/%h", imem_rmask, imem_addr, RESET_PC); else passes++;
        checks++; if (count !== 3'd0 || deq_valid !== 1'b0 || deq_pc !== 32'h0 || deq_inst !== 32'h0) $display("FAIL rst_mid_deq got %0d/%b/%h/%h want 0/0/0/0", count, deq_valid, deq_pc, deq_inst); else passes++;
        @(posedge clk); #1;
        rst_n = 1'b1; imem_resp = 1'b1; imem_rdata = 32'hBAD0_BAD0;
        #1;
        tick();
        imem_resp = 1'b0;
        #1;
        checks++; if (count !== 3'd0) $display("FAIL rst_stray_ignored got %0d want 0", count); else passes++;
        checks++; if (imem_rmask !== 4'hF || imem_addr !== RESET_PC) $display("FAIL rst_restart got %h/%h want f/%h", imem_rmask, imem_addr, RESET_PC); else passes++;
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_fill();
        test_stream_order();
        test_redirect_wait();
        test_redirect_resp_deq();
        test_pc_wrap();
        test_random();
        test_reset_mid_wait();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
